// File: rtl/muldiv_unit_e_pkg.sv
// Shared definitions for the RV32M iterative multiply/divide unit.
// Holds the funct3 op codes, the FSM state encoding and the default widths,
// plus small helpers that decide operand signedness from the op code.
package muldiv_unit_e_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int CNT_W_DEF = 5;

    localparam logic [2:0] MD_MUL    = 3'd0;
    localparam logic [2:0] MD_MULH   = 3'd1;
    localparam logic [2:0] MD_MULHSU = 3'd2;
    localparam logic [2:0] MD_MULHU  = 3'd3;
    localparam logic [2:0] MD_DIV    = 3'd4;
    localparam logic [2:0] MD_DIVU   = 3'd5;
    localparam logic [2:0] MD_REM    = 3'd6;
    localparam logic [2:0] MD_REMU   = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } md_state_t;

    // rs1 is signed for MUL, MULH, MULHSU, DIV and REM
    function automatic logic is_a_signed(input logic [2:0] op);
        return (op == MD_MUL) || (op == MD_MULH) || (op == MD_MULHSU) ||
               (op == MD_DIV) || (op == MD_REM);
    endfunction

    // rs2 is signed for MUL, MULH, DIV and REM
    function automatic logic is_b_signed(input logic [2:0] op);
        return (op == MD_MUL) || (op == MD_MULH) ||
               (op == MD_DIV) || (op == MD_REM);
    endfunction

endpackage

// File: rtl/md_signfix.sv
// Combinational sign helpers: operand magnitudes/sign bits at accept, and a
// conditional 2*XLEN negate used to sign-correct the result entering DONE.
// Ports: a/b + signedness in -> mag_a/mag_b/neg_a/neg_b; fix_in/fix_neg -> fix_out.
module md_signfix #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0]   a,
    input  logic [XLEN-1:0]   b,
    input  logic              a_signed,
    input  logic              b_signed,
    output logic [XLEN-1:0]   mag_a,
    output logic [XLEN-1:0]   mag_b,
    output logic              neg_a,
    output logic              neg_b,
    input  logic [2*XLEN-1:0] fix_in,
    input  logic              fix_neg,
    output logic [2*XLEN-1:0] fix_out
);

    assign neg_a   = a_signed & a[XLEN-1];
    assign neg_b   = b_signed & b[XLEN-1];
    // the most negative value maps onto itself, which is its correct unsigned magnitude
    assign mag_a   = neg_a ? (~a + 1'b1) : a;
    assign mag_b   = neg_b ? (~b + 1'b1) : b;
    assign fix_out = fix_neg ? (~fix_in + 1'b1) : fix_in;

endmodule

// File: rtl/muldiv_unit_e.sv
// Iterative RV32M multiply/divide unit for the execute stage: XLEN-cycle
// shift-add multiply or restoring divide, stalling the pipeline until done.
// Ports: clk/rst, start/op/src_a/src_b/flush in; stall/busy/done/result out.
module muldiv_unit_e
    import muldiv_unit_e_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic            flush,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    md_state_t         state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        op_q;
    logic [XLEN-1:0]   mag_b_q;
    // multiply: {partial product high, multiplier/product low}
    // divide:   {partial remainder, dividend/quotient}
    logic [2*XLEN-1:0] acc;
    logic              neg_res_q;
    logic              neg_rem_q;

    logic [XLEN-1:0]   mag_a, mag_b;
    logic              neg_a, neg_b;
    logic [2*XLEN-1:0] fix_in, fix_out;
    logic              fix_neg;

    logic              accept;
    logic              spec_dz, spec_ov, special;
    logic [XLEN-1:0]   spec_res;

    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_nxt;
    logic [XLEN+1:0]   div_diff;
    logic              div_ge;
    logic [2*XLEN-1:0] div_nxt;
    logic [2*XLEN-1:0] acc_step;
    logic [XLEN-1:0]   final_res;

    md_signfix #(.XLEN(XLEN)) u_signfix (
        .a        (src_a),
        .b        (src_b),
        .a_signed (is_a_signed(op)),
        .b_signed (is_b_signed(op)),
        .mag_a    (mag_a),
        .mag_b    (mag_b),
        .neg_a    (neg_a),
        .neg_b    (neg_b),
        .fix_in   (fix_in),
        .fix_neg  (fix_neg),
        .fix_out  (fix_out)
    );

    assign accept = (state == ST_IDLE) & start & ~flush;

    // Divide-by-zero and signed overflow bypass the iteration entirely
    assign spec_dz  = op[2] & (src_b == '0);
    assign spec_ov  = ((op == MD_DIV) || (op == MD_REM)) &&
                      (src_a == {1'b1, {(XLEN-1){1'b0}}}) && (src_b == '1);
    assign special  = spec_dz | spec_ov;
    // op[1] distinguishes REM/REMU from DIV/DIVU
    assign spec_res = spec_dz ? (op[1] ? src_a : '1)
                              : (op[1] ? '0 : src_a);

    // One multiply step: conditionally add multiplicand, shift right
    assign mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mag_b_q} : '0);
    assign mul_nxt = {mul_sum, acc[XLEN-1:1]};

    // One restoring divide step: shift left, trial-subtract divisor
    assign div_diff = {1'b0, acc[2*XLEN-1:XLEN-1]} - {2'b00, mag_b_q};
    assign div_ge   = ~div_diff[XLEN+1];
    assign div_nxt  = {(div_ge ? div_diff[XLEN-1:0] : acc[2*XLEN-2:XLEN-1]),
                       acc[XLEN-2:0], div_ge};

    assign acc_step = op_q[2] ? div_nxt : mul_nxt;

    // Sign correction on the value produced by the final iteration
    always_comb begin
        fix_in  = acc_step;
        fix_neg = neg_res_q;
        if (op_q[2]) begin
            if (op_q[1]) begin
                fix_in  = {{XLEN{1'b0}}, acc_step[2*XLEN-1:XLEN]};
                fix_neg = neg_rem_q;
            end else begin
                fix_in  = {{XLEN{1'b0}}, acc_step[XLEN-1:0]};
            end
        end
    end

    assign final_res = (!op_q[2] && (op_q != MD_MUL)) ? fix_out[2*XLEN-1:XLEN]
                                                      : fix_out[XLEN-1:0];

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && !flush) begin
                    stall     = 1'b1;
                    state_nxt = special ? ST_DONE : ST_CALC;
                end
            end
            ST_CALC: begin
                stall = 1'b1;
                if (flush)
                    state_nxt = ST_IDLE;
                else if (cnt == '0)
                    state_nxt = ST_DONE;
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            op_q      <= '0;
            mag_b_q   <= '0;
            acc       <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result    <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_q      <= op;
                acc       <= {{XLEN{1'b0}}, mag_a};
                mag_b_q   <= mag_b;
                neg_res_q <= neg_a ^ neg_b;
                neg_rem_q <= neg_a;
                cnt       <= CNT_W'(XLEN-1);
                if (special)
                    result <= spec_res;
            end else if (state == ST_CALC && !flush) begin
                acc <= acc_step;
                cnt <= cnt - 1'b1;
                if (cnt == '0)
                    result <= final_res;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit_e.sv
module tb_muldiv_unit_e;
    import muldiv_unit_e_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] src_a, src_b;
    logic        flush;
    logic        stall, busy, done;
    logic [31:0] result;

    int total = 0;
    int bad   = 0;

    muldiv_unit_e #(.XLEN(32), .CNT_W(5)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .src_a  (src_a),
        .src_b  (src_b),
        .flush  (flush),
        .stall  (stall),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_res;
        int          exp_lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Reference model: plain RV32M arithmetic on 64-bit integers
    function automatic logic [31:0] ref_res(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint     sa = longint'($signed(a));
        longint     sb = longint'($signed(b));
        longint     ua = longint'({32'd0, a});
        longint     ub = longint'({32'd0, b});
        int         ia = $signed(a);
        int         ib = $signed(b);
        logic [63:0] p;
        logic        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (o)
            MD_MUL:    begin p = 64'(sa * sb); return p[31:0];  end
            MD_MULH:   begin p = 64'(sa * sb); return p[63:32]; end
            MD_MULHSU: begin p = 64'(sa * ub); return p[63:32]; end
            MD_MULHU:  begin p = 64'(ua * ub); return p[63:32]; end
            MD_DIV:    return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(ia / ib);
            MD_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            MD_REM:    return (b == 0) ? a : ovf ? 32'd0 : 32'(ia % ib);
            default:   return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        if (o >= 3'd4 && b == 0) return 1;
        if ((o == MD_DIV || o == MD_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Issue one op from IDLE, then count cycles until done (cycle 0 = start sampled)
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        int lat;
        logic stall_ok;
        for (int i = 0; i < 4 && busy; i++) @(negedge clk);
        op = o; src_a = a; src_b = b; start = 1'b1;
        #1;
        check({tag, "/stall_c0"}, 32'(stall), 32'd1);
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0;
        stall_ok = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (done) begin
                lat = k;
                break;
            end
            if (!stall) stall_ok = 1'b0;
        end
        check({tag, "/latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "/result"}, result, exp_res);
        check({tag, "/stall_hold"}, 32'(stall_ok), 32'd1);
        check({tag, "/stall_done"}, 32'(stall), 32'd0);
    endtask

    vec_t vecs[$];

    initial begin
        logic        done_seen;
        logic [31:0] prev;
        int          gap;

        vecs = '{
            '{MD_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33},
            '{MD_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33},
            '{MD_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33},
            '{MD_MULHSU, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 33},
            '{MD_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33},
            '{MD_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33},
            '{MD_DIVU,   32'd100,        32'd7,         32'd14,        33},
            '{MD_REMU,   32'd100,        32'd7,         32'd2,         33},
            '{MD_DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF, 1},
            '{MD_REM,    32'd5,          32'd0,         32'd5,         1},
            '{MD_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1},
            '{MD_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1}
        };

        rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; src_a = '0; src_b = '0;
        repeat (2) @(negedge clk);
        check("reset/result", result, 32'd0);
        check("reset/busy",   32'(busy),  32'd0);
        check("reset/done",   32'(done),  32'd0);
        check("reset/stall",  32'(stall), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        foreach (vecs[i])
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].exp_res, vecs[i].exp_lat);

        // flush during CALC: no done, result untouched, idle next cycle
        @(negedge clk);
        prev = result;
        op = MD_DIV; src_a = 32'd100; src_b = 32'd7; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        done_seen = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (done) done_seen = 1'b1;
        end
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        if (done) done_seen = 1'b1;
        check("flush/busy",   32'(busy),  32'd0);
        check("flush/stall",  32'(stall), 32'd0);
        check("flush/nodone", 32'(done_seen), 32'd0);
        check("flush/result", result, prev);
        @(negedge clk);
        run_op("after_flush", MD_MUL, 32'd3, 32'd4, 32'd12, 33);

        // start together with flush in IDLE is not accepted
        @(negedge clk);
        op = MD_MUL; src_a = 32'd5; src_b = 32'd5; start = 1'b1; flush = 1'b1;
        #1;
        check("idleflush/stall", 32'(stall), 32'd0);
        @(posedge clk);
        #1 start = 1'b0; flush = 1'b0;
        @(negedge clk);
        check("idleflush/busy", 32'(busy), 32'd0);

        // asynchronous reset in the middle of a multiply
        op = MD_MUL; src_a = 32'd123; src_b = 32'd456; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst/result", result, 32'd0);
        check("midrst/busy",   32'(busy), 32'd0);
        check("midrst/done",   32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // back-to-back: second start held through DONE, taken in the following IDLE cycle
        run_op("b2b_first", MD_DIVU, 32'd9, 32'd3, 32'd3, 33);
        op = MD_REMU; src_a = 32'd9; src_b = 32'd4; start = 1'b1;
        @(posedge clk);
        #1;
        check("b2b/idle_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1 start = 1'b0;
        gap = 0;
        for (int k = 2; k <= 45; k++) begin
            @(negedge clk);
            if (done) begin
                gap = k;
                break;
            end
        end
        check("b2b/gap",    32'(gap), 32'd34);
        check("b2b/result", result, 32'd1);

        // randomized ops against the reference model
        for (int n = 0; n < 24; n++) begin
            logic [2:0]  ro;
            logic [31:0] ra, rb;
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: begin ra = 32'($urandom_range(0, 300)); rb = 32'($urandom_range(1, 20)); end
                default: ;
            endcase
            run_op($sformatf("rand%0d", n), ro, ra, rb, ref_res(ro, ra, rb), ref_lat(ro, ra, rb));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
